// File: rtl/clock_mode_ctrl_pkg.sv
// Shared types and constants for the clock / stopwatch mode controller.
// State codes, blink field codes and default timing constants.
package clock_pkg;

    typedef enum logic [2:0] {
        RELOGIO      = 3'b000,
        CONFIG_HOR   = 3'b001,
        CONFIG_MIN   = 3'b010,
        CRON_PARADO  = 3'b011,
        CRON_RODANDO = 3'b100
    } state_t;

    localparam logic [1:0] BLINK_NONE = 2'b00;
    localparam logic [1:0] BLINK_HOR  = 2'b01;
    localparam logic [1:0] BLINK_MIN  = 2'b10;

    localparam logic [15:0] DEBOUNCE_DEFAULT = 16'd50000;
    localparam logic [23:0] HOLD_DEFAULT     = 24'd25000000;
    localparam logic [23:0] REPEAT_DEFAULT   = 24'd5000000;

    function automatic logic [1:0] blink_of(input state_t s);
        case (s)
            CONFIG_HOR: blink_of = BLINK_HOR;
            CONFIG_MIN: blink_of = BLINK_MIN;
            default:    blink_of = BLINK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/clock_mode_ctrl_if.sv
// Board-side bundle of the mode controller: time bases, switches,
// keys in; counter strobes and display decode out.
interface clock_mode_ctrl_if;

    logic       tick_1hz;
    logic       tick_100hz;
    logic       swState;
    logic       swHor;
    logic       swMin;
    logic       key0;
    logic       key1;
    logic       key2;
    logic       key3;
    logic       sec_en;
    logic       sec_clr;
    logic       hor_inc;
    logic       hor_dec;
    logic       min_inc;
    logic       min_dec;
    logic       sw_en;
    logic       sw_clr;
    logic       disp_sel;
    logic [1:0] blink;
    logic [2:0] mode;

    modport master (
        output tick_1hz, tick_100hz, swState, swHor, swMin,
        output key0, key1, key2, key3,
        input  sec_en, sec_clr, hor_inc, hor_dec, min_inc, min_dec,
        input  sw_en, sw_clr, disp_sel, blink, mode
    );

    modport slave (
        input  tick_1hz, tick_100hz, swState, swHor, swMin,
        input  key0, key1, key2, key3,
        output sec_en, sec_clr, hor_inc, hor_dec, min_inc, min_dec,
        output sw_en, sw_clr, disp_sel, blink, mode
    );

endinterface

// File: rtl/clock_mode_ctrl_key_conditioner.sv
// One active-low push key: 2-FF synchronizer, debounce, press pulse.
// down is the accepted level (1 = held); press marks release->press.
module key_conditioner
    import clock_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic down,
    output logic press
);

    logic        sync1;
    logic        sync2;
    logic        level;
    logic [15:0] count;

    // Accept a new level only after an unbroken run of differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            count <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                count <= '0;
            end else if (count == DEBOUNCE_CYCLES - 16'd1) begin
                count <= '0;
                level <= sync2;
                press <= ~sync2;
            end else begin
                count <= count + 16'd1;
            end
        end
    end

    assign down = ~level;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Operating-mode controller for the clock / stopwatch datapath:
// conditions switches and keys, issues one-cycle counter strobes.
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter logic [23:0] HOLD_CYCLES     = HOLD_DEFAULT,
    parameter logic [23:0] REPEAT_CYCLES   = REPEAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    clock_mode_ctrl_if.slave  bus
);

    logic        st_s1, st_s2, hor_s1, hor_s2, min_s1, min_s2;
    logic [3:0]  press;
    logic [3:2]  down;
    logic [1:0]  down_unused;
    state_t      state, next_state;
    logic        sw_running, next_running;
    logic        sw_trans, is_cfg, hold_keep, fire;
    logic        clr_ev, inc_ev, dec_ev;
    logic [23:0] hold_cnt;
    logic        repeating;
    logic        sec_en, sec_clr, hor_inc, hor_dec;
    logic        min_inc, min_dec, sw_en, sw_clr, disp_sel;
    logic [1:0]  blink;

    // Switch synchronizers; swState idles in clock view so reset cannot
    // bounce the FSM into the stopwatch before real inputs arrive.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_s1  <= 1'b1;
            st_s2  <= 1'b1;
            hor_s1 <= 1'b0;
            hor_s2 <= 1'b0;
            min_s1 <= 1'b0;
            min_s2 <= 1'b0;
        end else begin
            st_s1  <= bus.swState;
            st_s2  <= st_s1;
            hor_s1 <= bus.swHor;
            hor_s2 <= hor_s1;
            min_s1 <= bus.swMin;
            min_s2 <= min_s1;
        end
    end

    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) key0_cond (
        .clk(clk), .rst(rst), .key(bus.key0),
        .down(down_unused[0]), .press(press[0])
    );
    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) key1_cond (
        .clk(clk), .rst(rst), .key(bus.key1),
        .down(down_unused[1]), .press(press[1])
    );
    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) key2_cond (
        .clk(clk), .rst(rst), .key(bus.key2),
        .down(down[2]), .press(press[2])
    );
    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) key3_cond (
        .clk(clk), .rst(rst), .key(bus.key3),
        .down(down[3]), .press(press[3])
    );

    // Next state and key events; a switch transition swallows key presses.
    always_comb begin
        next_state   = state;
        next_running = sw_running;
        sw_trans     = 1'b0;
        case (state)
            RELOGIO: begin
                if (hor_s2) begin
                    next_state = CONFIG_HOR;
                    sw_trans   = 1'b1;
                end else if (min_s2) begin
                    next_state = CONFIG_MIN;
                    sw_trans   = 1'b1;
                end else if (!st_s2) begin
                    next_state = sw_running ? CRON_RODANDO : CRON_PARADO;
                    sw_trans   = 1'b1;
                end
            end
            CONFIG_HOR: begin
                if (!hor_s2) begin
                    next_state = RELOGIO;
                    sw_trans   = 1'b1;
                end
            end
            CONFIG_MIN: begin
                if (!min_s2) begin
                    next_state = RELOGIO;
                    sw_trans   = 1'b1;
                end
            end
            CRON_PARADO, CRON_RODANDO: begin
                if (st_s2) begin
                    next_state = RELOGIO;
                    sw_trans   = 1'b1;
                end else if (press[1]) begin
                    next_running = ~sw_running;
                    next_state   = next_running ? CRON_RODANDO : CRON_PARADO;
                end
            end
            default: next_state = RELOGIO;
        endcase
        is_cfg    = (state == CONFIG_HOR) || (state == CONFIG_MIN);
        hold_keep = is_cfg && !sw_trans && (down[2] ^ down[3]);
        fire      = hold_keep && (repeating ? (hold_cnt == REPEAT_CYCLES)
                                            : (hold_cnt == HOLD_CYCLES));
        clr_ev    = !sw_trans && (state == RELOGIO) && press[0];
        inc_ev    = !sw_trans && is_cfg &&
                    ((press[2] && !down[3]) || (fire && down[2]));
        dec_ev    = !sw_trans && is_cfg &&
                    ((press[3] && !down[2]) || (fire && down[3]));
    end

    // State register and stopwatch run flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RELOGIO;
            sw_running <= 1'b0;
        end else begin
            state      <= next_state;
            sw_running <= next_running;
        end
    end

    // Hold timer for key2/key3 auto-repeat in the config states.
    always_ff @(posedge clk) begin
        if (rst || !hold_keep) begin
            hold_cnt  <= '0;
            repeating <= 1'b0;
        end else if (fire) begin
            hold_cnt  <= 24'd1;
            repeating <= 1'b1;
        end else begin
            hold_cnt  <= hold_cnt + 24'd1;
        end
    end

    // Registered strobes and display decodes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sec_en   <= 1'b0;
            sec_clr  <= 1'b0;
            hor_inc  <= 1'b0;
            hor_dec  <= 1'b0;
            min_inc  <= 1'b0;
            min_dec  <= 1'b0;
            sw_en    <= 1'b0;
            sw_clr   <= 1'b0;
            disp_sel <= 1'b0;
            blink    <= BLINK_NONE;
        end else begin
            sec_en   <= bus.tick_1hz && !is_cfg && !clr_ev;
            sec_clr  <= clr_ev;
            hor_inc  <= inc_ev && (state == CONFIG_HOR);
            hor_dec  <= dec_ev && (state == CONFIG_HOR);
            min_inc  <= inc_ev && (state == CONFIG_MIN);
            min_dec  <= dec_ev && (state == CONFIG_MIN);
            sw_en    <= bus.tick_100hz && sw_running;
            sw_clr   <= !sw_trans && (state == CRON_PARADO) && press[0];
            disp_sel <= (next_state == CRON_PARADO) ||
                        (next_state == CRON_RODANDO);
            blink    <= blink_of(next_state);
        end
    end

    assign bus.sec_en   = sec_en;
    assign bus.sec_clr  = sec_clr;
    assign bus.hor_inc  = hor_inc;
    assign bus.hor_dec  = hor_dec;
    assign bus.min_inc  = min_inc;
    assign bus.min_dec  = min_dec;
    assign bus.sw_en    = sw_en;
    assign bus.sw_clr   = sw_clr;
    assign bus.disp_sel = disp_sel;
    assign bus.blink    = blink;
    assign bus.mode     = state;

endmodule
